uart_tx_feeder: RTL and testbench

Byte buffer and launch controller directly upstream of the UART transmit FSM/serializer. Accepts bytes from the system side into a DEPTH-entry synchronous FIFO. Whenever the transmitter is idle, it presents one byte on `P_DATA` with a single-cycle `Data_Valid` pulse. It then tracks the transmitter's `Busy` signal until the frame (start, data, optional parity, stop) has finished before launching the next byte.

---
 rtl/uart_tx_feeder.sv | 135 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: DEPTH-entry byte FIFO plus a launch controller that feeds
// one byte at a time to the UART transmit FSM and waits for its frame to end.
//
// Launch handshake: Data_Valid is a single-cycle pulse that moves the byte
// on P_DATA into the transmitter. The transmitter acknowledges by raising
// Busy, which stays high until the frame is finished. No new Data_Valid is
// issued until Busy has risen and fallen again, or until BUSY_TIMEOUT cycles
// pass without Busy rising, which abandons that byte and pulses TX_ERR.
// While Busy is high in IDLE, for whatever reason, nothing is launched.
module uart_tx_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int BUSY_TIMEOUT = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVF,
    output logic                  TX_ERR,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    input  logic                  Busy,
    output logic [1:0]            STATE_DBG
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0]         TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0]         TIMER_ONE  = TW'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [TW-1:0]         timer;
    state_t                state;
    logic                  do_write;
    logic                  do_pop;

    // Flags decode the registered count; FULL is the pre-edge view for writes.
    assign COUNT     = count;
    assign FULL      = (count == CNT_FULL);
    assign EMPTY     = (count == '0);
    assign STATE_DBG = state;

    assign do_write  = WR_EN && !FULL;
    assign do_pop    = (state == IDLE) && !EMPTY && !Busy;

    // Storage array; left unreset because count/pointers define validity.
    always_ff @(posedge CLK) begin
        if (RST && do_write) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    // Write pointer, occupancy count and dropped-write pulse.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            count  <= '0;
            OVF    <= 1'b0;
        end else begin
            OVF <= WR_EN && FULL;
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({do_write, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Launch FSM: pop in IDLE, pulse in LAUNCH, then follow Busy to frame end.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            timer      <= '0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            TX_ERR     <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            TX_ERR     <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        P_DATA     <= mem[rd_ptr];
                        rd_ptr     <= rd_ptr + PTR_ONE;
                        Data_Valid <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (Busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_LAST) begin
                        // Transmitter never acknowledged; drop the byte.
                        TX_ERR <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!Busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a small Tx model answers Data_Valid with a Busy
// window, launched bytes are compared against a queue of expected bytes.
module tb_uart_tx_feeder;

    localparam int DW           = 8;
    localparam int BUSY_TIMEOUT = 3;
    localparam int FRAME_LEN    = 11;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] WR_DATA;
    logic          WR_EN;
    logic          FULL;
    logic          EMPTY;
    logic [4:0]    COUNT;
    logic          OVF;
    logic          TX_ERR;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Busy;
    logic [1:0]    STATE_DBG;

    // Tx model controls
    int            tx_mode  = 0;   // 0: normal frame, 1: never raises Busy
    logic          ext_busy = 1'b0;
    int            tx_left  = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_byte;
    int            errors   = 0;
    int            checks   = 0;
    int            cyc      = 0;
    logic          dv_prev  = 1'b0;

    uart_tx_feeder #(
        .DATA_WIDTH  (8),
        .DEPTH       (16),
        .ADDR_WIDTH  (4),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WR_DATA   (WR_DATA),
        .WR_EN     (WR_EN),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT),
        .OVF       (OVF),
        .TX_ERR    (TX_ERR),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .Busy      (Busy),
        .STATE_DBG (STATE_DBG)
    );

    // Clock and cycle counter
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Tx model: Busy rises the cycle after Data_Valid and lasts FRAME_LEN cycles
    always @(posedge CLK) begin
        if (tx_left != 0) tx_left <= tx_left - 1;
        else if (Data_Valid && tx_mode == 0) tx_left <= FRAME_LEN;
    end
    assign Busy = (tx_left != 0) || ext_busy;

    // Scoreboard: every launch must match the oldest expected byte
    always @(negedge CLK) begin
        if (Data_Valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL launch_unexpected: P_DATA=%h with no byte expected", P_DATA);
            end else begin
                exp_byte = exp_q.pop_front();
                if (P_DATA !== exp_byte) begin
                    errors++;
                    $display("FAIL launch_data: P_DATA=%h expected %h", P_DATA, exp_byte);
                end
            end
            checks++;
            if (dv_prev) begin
                errors++;
                $display("FAIL dv_width: Data_Valid high two cycles in a row");
            end
        end
        dv_prev = Data_Valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (!(EMPTY && !Busy && STATE_DBG == 2'd0) && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL wait_idle: not idle after %0d cycles (count=%0d busy=%b)", max_cyc, COUNT, Busy);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; WR_EN = 1'b1; WR_DATA = 8'hEE;
        @(negedge CLK); @(negedge CLK);
        checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", Data_Valid); end
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata: got %h want 00", P_DATA); end
        checks++; if (OVF !== 1'b0 || TX_ERR !== 1'b0) begin errors++; $display("FAIL reset_pulses: ovf=%b tx_err=%b want 0 0", OVF, TX_ERR); end
        checks++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin errors++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", EMPTY, FULL); end
        checks++; if (COUNT !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", COUNT); end
        WR_EN = 1'b0; RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single();
        int dvs = 0;
        WR_EN = 1'b1; WR_DATA = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge CLK);                     // cycle n+1
        WR_EN = 1'b0;
        checks++; if (COUNT !== 5'd1 || EMPTY !== 1'b0) begin errors++; $display("FAIL single_count1: count=%0d empty=%b want 1 0", COUNT, EMPTY); end
        checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL single_dv_early: got %b want 0", Data_Valid); end
        @(negedge CLK);                     // cycle n+2
        checks++; if (Data_Valid !== 1'b1 || P_DATA !== 8'hA5) begin errors++; $display("FAIL single_launch: dv=%b p_data=%h want 1 a5", Data_Valid, P_DATA); end
        checks++; if (COUNT !== 5'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", COUNT); end
        @(negedge CLK);                     // cycle n+3
        checks++; if (Busy !== 1'b1 || Data_Valid !== 1'b0) begin errors++; $display("FAIL single_busy: busy=%b dv=%b want 1 0", Busy, Data_Valid); end
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (Data_Valid) dvs++;
            checks++; if (OVF !== 1'b0 || TX_ERR !== 1'b0) begin errors++; $display("FAIL single_pulses: ovf=%b tx_err=%b want 0 0", OVF, TX_ERR); end
        end
        checks++; if (dvs != 0) begin errors++; $display("FAIL single_relaunch: got %0d extra launches want 0", dvs); end
        wait_idle(40);
    endtask

    task automatic test_burst();
        int n_dv = 0, falls = 0, fall_cyc = 0, gap_bad = 0;
        logic prev_busy = 1'b0, stable_ok = 1'b1;
        logic [DW-1:0] cur = '0;
        for (int i = 0; i < 200 && !(n_dv >= 3 && falls >= 3); i++) begin
            if (i < 3) begin
                WR_EN = 1'b1; WR_DATA = DW'(i + 1); exp_q.push_back(DW'(i + 1));
            end else WR_EN = 1'b0;
            @(negedge CLK);
            if (prev_busy && !Busy) begin falls++; fall_cyc = cyc; end
            if (Data_Valid) begin
                n_dv++;
                cur = P_DATA;
                if (n_dv >= 2 && (cyc - fall_cyc) != 2) begin
                    gap_bad++;
                    $display("FAIL burst_gap: launch %0d came %0d cycles after Busy fall, want 2", n_dv, cyc - fall_cyc);
                end
            end else if (Busy && P_DATA !== cur) stable_ok = 1'b0;
            prev_busy = Busy;
        end
        WR_EN = 1'b0;
        checks++; if (n_dv != 3) begin errors++; $display("FAIL burst_launches: got %0d want 3", n_dv); end
        checks++; if (gap_bad != 0) errors++;
        checks++; if (!stable_ok) begin errors++; $display("FAIL burst_stable: P_DATA changed while Busy, got 0 want 1"); end
        wait_idle(40);
    endtask

    task automatic test_overflow();
        int n = 0;
        ext_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            WR_EN = 1'b1; WR_DATA = DW'(8'h10 + i);
            if (i < 16) exp_q.push_back(DW'(8'h10 + i));
            @(negedge CLK);
            if (i == 15) begin
                checks++; if (FULL !== 1'b1 || COUNT !== 5'd16) begin errors++; $display("FAIL ovf_full: full=%b count=%0d want 1 16", FULL, COUNT); end
                checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", OVF); end
            end
        end
        WR_EN = 1'b0;
        checks++; if (OVF !== 1'b1 || COUNT !== 5'd16) begin errors++; $display("FAIL ovf_pulse: ovf=%b count=%0d want 1 16", OVF, COUNT); end
        @(negedge CLK);
        checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL ovf_width: got %b want 0", OVF); end
        ext_busy = 1'b0;
        while ((exp_q.size() != 0 || !EMPTY) && n < 400) begin @(negedge CLK); n++; end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain: %0d bytes left want 0", exp_q.size()); end
        wait_idle(40);
    endtask

    task automatic test_simul();
        ext_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WR_EN = 1'b1; WR_DATA = DW'(8'hB0 + i); exp_q.push_back(DW'(8'hB0 + i));
            @(negedge CLK);
        end
        checks++; if (COUNT !== 5'd3) begin errors++; $display("FAIL simul_pre: count=%0d want 3", COUNT); end
        ext_busy = 1'b0; WR_EN = 1'b1; WR_DATA = 8'hB3; exp_q.push_back(8'hB3);
        @(negedge CLK);
        WR_EN = 1'b0;
        checks++; if (COUNT !== 5'd3) begin errors++; $display("FAIL simul_count: got %0d want 3", COUNT); end
        checks++; if (Data_Valid !== 1'b1) begin errors++; $display("FAIL simul_launch: dv=%b want 1", Data_Valid); end
        wait_idle(100);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL simul_drain: %0d bytes left want 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int dv_c[2], te_c[2];
        int n_dv = 0, n_te = 0;
        logic prev_te = 1'b0;
        tx_mode = 1;
        for (int i = 0; i < 60 && n_te < 2; i++) begin
            if (i < 2) begin
                WR_EN = 1'b1; WR_DATA = DW'(8'hC1 + i); exp_q.push_back(DW'(8'hC1 + i));
            end else WR_EN = 1'b0;
            @(negedge CLK);
            if (Data_Valid && n_dv < 2) begin dv_c[n_dv] = cyc; n_dv++; end
            if (TX_ERR) begin
                if (n_te < 2) te_c[n_te] = cyc;
                n_te++;
                checks++; if (prev_te) begin errors++; $display("FAIL timeout_width: TX_ERR high two cycles"); end
            end
            prev_te = TX_ERR;
        end
        WR_EN = 1'b0;
        checks++;
        if (n_dv != 2 || n_te != 2) begin
            errors++; $display("FAIL timeout_counts: launches=%0d tx_err=%0d want 2 2", n_dv, n_te);
        end else begin
            checks++; if (te_c[0] != dv_c[0] + 1 + BUSY_TIMEOUT) begin errors++; $display("FAIL timeout_err1: at +%0d want +%0d", te_c[0] - dv_c[0], 1 + BUSY_TIMEOUT); end
            checks++; if (dv_c[1] != te_c[0] + 1) begin errors++; $display("FAIL timeout_next: launch at +%0d after TX_ERR want +1", dv_c[1] - te_c[0]); end
            checks++; if (te_c[1] != dv_c[1] + 1 + BUSY_TIMEOUT) begin errors++; $display("FAIL timeout_err2: at +%0d want +%0d", te_c[1] - dv_c[1], 1 + BUSY_TIMEOUT); end
        end
        tx_mode = 0;
        wait_idle(40);
    endtask

    task automatic test_reset_mid();
        int dvs = 0, falls = 0;
        logic prev_busy;
        for (int i = 0; i < 6; i++) begin
            WR_EN = 1'b1; WR_DATA = DW'(8'hE0 + i);
            if (i == 0) exp_q.push_back(8'hE0);
            @(negedge CLK);
        end
        WR_EN = 1'b0;
        checks++; if (COUNT !== 5'd5 || STATE_DBG !== 2'd3) begin errors++; $display("FAIL mid_pre: count=%0d state=%0d want 5 3", COUNT, STATE_DBG); end
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        checks++; if (COUNT !== 5'd0 || EMPTY !== 1'b1) begin errors++; $display("FAIL mid_flags: count=%0d empty=%b want 0 1", COUNT, EMPTY); end
        checks++; if (Data_Valid !== 1'b0 || P_DATA !== 8'h00) begin errors++; $display("FAIL mid_out: dv=%b p_data=%h want 0 00", Data_Valid, P_DATA); end
        prev_busy = Busy;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (Data_Valid) dvs++;
            if (prev_busy && !Busy) falls++;
            prev_busy = Busy;
        end
        checks++; if (falls != 1) begin errors++; $display("FAIL mid_busy_fall: got %0d falls want 1", falls); end
        checks++; if (dvs != 0) begin errors++; $display("FAIL mid_launch: got %0d launches want 0", dvs); end
    endtask

    initial begin
        RST = 1'b0; WR_EN = 1'b0; WR_DATA = '0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_simul();
        test_timeout();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d bytes never launched want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
